// File: rtl/cla_seq_adder_pkg.sv
// Shared widths, slice count and FSM state type for the byte-serial CLA adder.
package cla_seq_adder_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla8_slice.sv
// 8-bit carry-lookahead slice: every internal carry is a flat sum of
// generate/propagate products, with no carry chained from the previous bit.
module cla8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       G,
  output logic       P,
  output logic       c7,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] grp_g;
  logic [7:0] grp_p;
  logic [7:0] term [8];
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // grp_g[i]/grp_p[i] span bits i..0; term[i][j] = g[j] & p[i]..p[j+1]
  for (genvar i = 0; i < 8; i++) begin : g_grp
    localparam logic [7:0] PMASK = 8'hFF >> (7 - i);
    for (genvar j = 0; j < 8; j++) begin : g_term
      localparam logic [7:0] TMASK = (8'hFF << (j + 1)) & PMASK;
      if (j <= i) begin : g_live
        assign term[i][j] = g[j] & (&(p | ~TMASK));
      end else begin : g_dead
        assign term[i][j] = 1'b0;
      end
    end
    assign grp_g[i] = |term[i];
    assign grp_p[i] = &(p | ~PMASK);
    assign c[i+1]   = grp_g[i] | (grp_p[i] & cin);
  end

  assign c[0] = cin;
  assign sum  = p ^ c[7:0];
  assign G    = grp_g[7];
  assign P    = grp_p[7];
  assign c7   = c[7];
  assign cout = c[8];

endmodule

// File: rtl/cla_seq_adder.sv
// Byte-serial 32-bit add/subtract: one 8-bit lookahead slice reused over
// four RUN cycles, with a valid/ready handshake on both sides.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = cla_seq_adder_pkg::WIDTH,
  parameter int unsigned SLICE = cla_seq_adder_pkg::SLICE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               sub_reg;
  logic               carry_reg;
  logic [1:0]         k;
  logic               accept;
  logic               last;
  logic [SLICE-1:0]   a_byte, b_byte, s_byte;
  logic               s_cin, s_g, s_p, s_c7, s_cout;

  always_comb begin
    state_d   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && (state == IDLE);
    last      = (k == 2'(NSLICE - 1));
    unique case (state)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_byte = a_reg[0*SLICE +: SLICE];
    b_byte = b_reg[0*SLICE +: SLICE];
    unique case (k)
      2'd0: begin a_byte = a_reg[0*SLICE +: SLICE]; b_byte = b_reg[0*SLICE +: SLICE]; end
      2'd1: begin a_byte = a_reg[1*SLICE +: SLICE]; b_byte = b_reg[1*SLICE +: SLICE]; end
      2'd2: begin a_byte = a_reg[2*SLICE +: SLICE]; b_byte = b_reg[2*SLICE +: SLICE]; end
      default: begin a_byte = a_reg[3*SLICE +: SLICE]; b_byte = b_reg[3*SLICE +: SLICE]; end
    endcase
  end

  // carry_reg already holds sub on the first slice; the mux makes that explicit
  assign s_cin = (k == 2'd0) ? sub_reg : carry_reg;

  cla8_slice u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (s_cin),
    .sum  (s_byte),
    .G    (s_g),
    .P    (s_p),
    .c7   (s_c7),
    .cout (s_cout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      k         <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_reg     <= operand_a;
        b_reg     <= operand_b ^ {WIDTH{sub}};
        sub_reg   <= sub;
        carry_reg <= sub;
        k         <= '0;
      end else if (state == RUN) begin
        unique case (k)
          2'd0:    result[0*SLICE +: SLICE] <= s_byte;
          2'd1:    result[1*SLICE +: SLICE] <= s_byte;
          2'd2:    result[2*SLICE +: SLICE] <= s_byte;
          default: result[3*SLICE +: SLICE] <= s_byte;
        endcase
        carry_reg <= s_cout;
        k         <= k + 2'd1;
        if (last) begin
          carry_out <= s_g | (s_p & s_cin);
          overflow  <= s_c7 ^ s_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks of cla_seq_adder against a plain-arithmetic model.
module tb_cla_seq_adder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cla_seq_adder #(.WIDTH(32), .SLICE(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 33-bit arithmetic sum, signed overflow from operand/result signs.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic v);
    logic [32:0] wide;
    if (s) wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else   wide = {1'b0, a} + {1'b0, b};
    r = wide[31:0];
    c = wide[32];
    if (s) v = (a[31] != b[31]) && (r[31] != a[31]);
    else   v = (a[31] == b[31]) && (r[31] != a[31]);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, input bit scramble);
    logic [31:0] er;
    logic        ec, ev;
    model(a, b, s, er, ec, ev);
    @(negedge clock);
    operand_a = a; operand_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    check("ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    if (scramble) begin
      operand_a = 32'hAAAAAAAA ^ $urandom; operand_b = $urandom; sub = ~s;
    end else begin
      in_valid = 1'b0;
    end
    check("run_valid_low", 64'(out_valid), 64'd0);
    check("run_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("latency_valid_low", 64'(out_valid), 64'd0);
      check("run_ready_low", 64'(in_ready), 64'd0);
      if (scramble) begin operand_a = $urandom; operand_b = $urandom; end
    end
    @(posedge clock); #1;
    check("latency_valid_high", 64'(out_valid), 64'd1);
    check("result", 64'(result), 64'(er));
    check("carry_out", 64'(carry_out), 64'(ec));
    check("overflow", 64'(overflow), 64'(ev));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'(er));
      check("hold_carry", 64'(carry_out), 64'(ec));
      check("hold_ovf", 64'(overflow), 64'(ev));
      check("hold_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("idle_valid_low", 64'(out_valid), 64'd0);
    check("idle_ready_high", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);
    check("reset_result", 64'(result), 64'd0);
    check("reset_carry", 64'(carry_out), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    check("d1_result", 64'(result), 64'h00000000);
    check("d1_carry", 64'(carry_out), 64'd1);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    check("d2_result", 64'(result), 64'h80000000);
    check("d2_ovf", 64'(overflow), 64'd1);
    run_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0);
    check("d3_result", 64'(result), 64'hFFFFFFFE);
    check("d3_carry", 64'(carry_out), 64'd0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 5, 1'b0);
    check("d4_result", 64'(result), 64'h23456789);
    run_op(32'h12345678, 32'h11111111, 1'b0, 2, 1'b1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1, 1'b0);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0);

    // Reset after the second RUN edge aborts the operation.
    @(negedge clock);
    operand_a = 32'hDEADBEEF; operand_b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    check("abort_carry", 64'(carry_out), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("abort_no_pulse", 64'(out_valid), 64'd0);
    end
    run_op(32'h00000002, 32'h00000003, 1'b0, 0, 1'b0);
    check("post_abort_result", 64'(result), 64'h00000005);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; fixed at 32.
REQ-002 Parameter SLICE, default 8, bits added per cycle; WIDTH/SLICE = 4 slices.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 operand_a  input  32  first operand.
REQ-008 operand_b  input  32  second operand.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  32  sum or difference, registered.
REQ-013 carry_out  output  1  carry out of bit 31; for subtract, 1 means no borrow.
REQ-014 overflow  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE).
REQ-017 out_valid SHALL equal (state==DONE).
REQ-018 Accept: on an edge with in_valid & in_ready, the block SHALL register A, B^{32{sub}} and sub, set carry_reg=sub, set slice index k=0, and enter RUN.
REQ-019 In RUN, each edge SHALL:
  - add byte k of the registered A and B with carry_reg through the 8-bit CLA slice;
  - write the sum into result[8k+7:8k];
  - load the slice carry-out into carry_reg;
  - increment k.
REQ-020 Slice carries SHALL be generated by lookahead: group generate = g7 | p7g6 | ... | p7..p1g0, and carry-out = G | P&cin. Ripple chaining inside the slice is not allowed.
REQ-021 On the edge that processes k=3, the FSM SHALL enter DONE and register the following:
  - carry_out = slice carry-out;
  - overflow = (carry into bit 31) XOR (carry out of bit 31).
REQ-022 Latency: an accept at edge E SHALL give out_valid=1 after edge E+4 (exactly 4 RUN cycles).
REQ-023 DONE SHALL hold result, carry_out and overflow stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-024 There is no DONE->RUN bypass. The minimum request-to-request spacing is 6 cycles when out_ready is held high.
REQ-025 in_valid, operand and sub changes during RUN or DONE SHALL be ignored and SHALL NOT corrupt the in-flight operation.
REQ-026 k SHALL wrap 3->0 only via a new accept; k is don't-care outside RUN.
REQ-027 Upper result bytes not yet written during RUN SHALL retain their previous values. result is only defined while out_valid=1.

Reset
REQ-028 Assertion of reset (low), at any time including mid-RUN, SHALL immediately:
  - place the FSM in IDLE;
  - clear result, carry_out, overflow, carry_reg, k and the operand registers to 0;
  - abort any in-flight operation with no result emitted.
REQ-029 While in reset, and after reset is released, out_valid=0 and in_ready=1. The first accept is possible on the first edge after release.

Structure
REQ-030 A shared package SHALL hold:
  - WIDTH and SLICE;
  - the number of slices (4);
  - the state enum {IDLE, RUN, DONE}.
REQ-031 The 8-bit lookahead slice SHALL be a separate sub-module cla8_slice.
  - Inputs: a[7:0], b[7:0], cin.
  - Outputs: sum[7:0], G, P, c7 (carry into bit 7), cout.
  - It is instantiated once.
REQ-032 The per-byte operand selection SHALL be a 4:1 multiplexer indexed by k. No shifting of the operand registers is permitted.

Verification
REQ-033 A=0xFFFFFFFF, B=0x00000001, sub=0 -> out_valid 4 cycles after accept; result=0x00000000, carry_out=1, overflow=0.
REQ-034 A=0x7FFFFFFF, B=0x00000001, sub=0 -> result=0x80000000, carry_out=0, overflow=1.
REQ-035 A=0x00000005, B=0x00000007, sub=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
REQ-036 A=0x12345678, B=0x11111111, sub=0 with out_ready=0 for 5 cycles -> result=0x23456789 held stable with out_valid=1 throughout; the FSM returns to IDLE on the edge where out_ready rises.
REQ-037 Changing in_valid and operands during RUN (e.g. A=0xAAAAAAAA) -> the original result is unaffected and in_ready stays 0 until IDLE.
REQ-038 reset low for 1 cycle after the second RUN edge -> outputs are 0 and the FSM is in IDLE with no out_valid pulse; a subsequent request of 0x00000002+0x00000003 returns 0x00000005.
